ssp_rx_fifo_param: RTL and testbench

Parametrised receive FIFO for the SSP peripheral, sitting between the serial receive shifter (write side) and the APB-style register interface (read side). It generalises the fixed 4×8 receive queue to configurable width and depth. Everything runs on a single rising clock edge. It adds occupancy reporting, empty/full flags, a programmable watermark interrupt, and optional overrun detection.

---
 rtl/ssp_rx_fifo_param.sv | 123 ++++++++++++
 tb/tb_ssp_rx_fifo_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : ssp_rx_fifo_param
//  Purpose  : Parametrised SSP receive FIFO. The serial receive shifter pushes
//             on the write side. The APB-style register interface pops on the
//             read side. Reads are first-word fall-through. The block also
//             reports occupancy, empty/full flags, a watermark interrupt and
//             an optional sticky overrun flag.
//  Ports    : PCLK      - clock, rising edge
//             CLEAR     - synchronous active-high reset, highest priority
//             PSEL      - peripheral select
//             PWRITE    - bus direction; PSEL & ~PWRITE requests a pop
//             WR        - push strobe, one entry per cycle
//             IN_DATA   - push data
//             OVR_CLR   - clears sticky OVERRUN
//             OUT_DATA  - head entry, 0 when empty
//             EMPTY     - occupancy == 0
//             FULL      - occupancy == DEPTH
//             COUNT     - occupancy, 0..DEPTH
//             SSPRXINTR - level interrupt, COUNT >= RX_WATERMARK
//             OVERRUN   - sticky flag, set when a push was dropped
//  Config   : define SSP_RX_OVERRUN_EN to build the OVERRUN register. When it
//             is not defined, OVERRUN is tied to 0 and OVR_CLR is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module ssp_rx_fifo_param #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int DEPTH        = 4,
    parameter  int RX_WATERMARK = DEPTH,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic                  WR,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  OVR_CLR,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [CW-1:0]         COUNT,
    output logic                  SSPRXINTR,
    output logic                  OVERRUN
);

    localparam int c_PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]       r_wp;
    logic [c_PW-1:0]       r_rp;
    // A separate occupancy count removes the full/empty ambiguity when the
    // write and read pointers are equal.
    logic [CW-1:0]         r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    // A pop is evaluated against the registered EMPTY flag. A push into an
    // empty FIFO therefore cannot be popped in the same cycle.
    assign w_pop   = PSEL & ~PWRITE & ~w_empty;
    // A full FIFO accepts a push only when a pop frees a slot on the same edge.
    assign w_push  = WR & (~w_full | w_pop);

    // The storage array is not reset. CLEAR discards any push in its cycle.
    always_ff @(posedge PCLK) begin
        if (w_push && !CLEAR) begin
            r_mem[r_wp] <= IN_DATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef SSP_RX_OVERRUN_EN
    logic r_overrun;

    // If a drop and OVR_CLR occur on the same edge, the new drop wins so
    // the event is never lost.
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_overrun <= 1'b0;
        end else if (WR && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (OVR_CLR) begin
            r_overrun <= 1'b0;
        end
    end

    assign OVERRUN = r_overrun;
`else
    logic w_unused_ovr_clr;

    assign w_unused_ovr_clr = OVR_CLR;
    assign OVERRUN          = 1'b0;
`endif

    // All outputs come from registered state only.
    assign OUT_DATA  = w_empty ? '0 : r_mem[r_rp];
    assign EMPTY     = w_empty;
    assign FULL      = w_full;
    assign COUNT     = r_cnt;
    assign SSPRXINTR = (r_cnt >= CW'(RX_WATERMARK));

endmodule
`default_nettype wire

// File: tb/tb_ssp_rx_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssp_rx_fifo_param
//  Purpose  : Self-checking bench for ssp_rx_fifo_param. Instance A uses the
//             default 4x8 FIFO with the watermark at 4. Instance B is an 8x8
//             FIFO with the watermark at 3. A queue-based reference model
//             tracks both instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssp_rx_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, RX_WATERMARK=4
    logic       a_clear = 1'b0, a_psel = 1'b0, a_pwrite = 1'b0, a_wr = 1'b0, a_oclr = 1'b0;
    logic [7:0] a_din = '0, a_out;
    logic       a_empty, a_full, a_intr, a_ovr;
    logic [2:0] a_cnt;
    // Instance B: DEPTH=8, RX_WATERMARK=3
    logic       b_clear = 1'b0, b_psel = 1'b0, b_pwrite = 1'b0, b_wr = 1'b0, b_oclr = 1'b0;
    logic [7:0] b_din = '0, b_out;
    logic       b_empty, b_full, b_intr, b_ovr;
    logic [3:0] b_cnt;

    ssp_rx_fifo_param #(.DATA_WIDTH(8), .DEPTH(4)) u_dut_a (
        .PCLK(clk), .CLEAR(a_clear), .PSEL(a_psel), .PWRITE(a_pwrite), .WR(a_wr),
        .IN_DATA(a_din), .OVR_CLR(a_oclr), .OUT_DATA(a_out), .EMPTY(a_empty),
        .FULL(a_full), .COUNT(a_cnt), .SSPRXINTR(a_intr), .OVERRUN(a_ovr)
    );

    ssp_rx_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .RX_WATERMARK(3)) u_dut_b (
        .PCLK(clk), .CLEAR(b_clear), .PSEL(b_psel), .PWRITE(b_pwrite), .WR(b_wr),
        .IN_DATA(b_din), .OVR_CLR(b_oclr), .OUT_DATA(b_out), .EMPTY(b_empty),
        .FULL(b_full), .COUNT(b_cnt), .SSPRXINTR(b_intr), .OVERRUN(b_ovr)
    );

`ifdef SSP_RX_OVERRUN_EN
    localparam bit c_OVR_EN = 1'b1;
`else
    localparam bit c_OVR_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         m_ovr[2];

    // Sampled DUT outputs and model expectations
    logic [7:0] act_out, exp_out;
    bit         act_empty, act_full, act_intr, act_ovr;
    bit         exp_empty, exp_full, exp_intr, exp_ovr;
    int         act_cnt, exp_cnt;

    task automatic model_step(input int sel, input bit clr, input bit wr, input logic [7:0] din,
                              input bit psel, input bit pwrite, input bit oclr);
        logic [7:0] q[$];
        int dep;
        bit emp, ful, pop, push;
        if (sel == 0) q = qa; else q = qb;
        dep = (sel == 0) ? 4 : 8;
        if (clr) begin
            q.delete();
            m_ovr[sel] = 1'b0;
        end else begin
            emp  = (q.size() == 0);
            ful  = (q.size() == dep);
            pop  = psel && !pwrite && !emp;
            push = wr && (!ful || pop);
            if (c_OVR_EN) begin
                if (wr && ful && !pop) m_ovr[sel] = 1'b1;
                else if (oclr)         m_ovr[sel] = 1'b0;
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(din);
        end
        if (sel == 0) qa = q; else qb = q;
    endtask

    // One clock cycle on the selected instance. The other instance idles.
    task automatic cycle(input int sel, input bit clr, input bit wr, input logic [7:0] din,
                         input bit psel, input bit pwrite, input bit oclr);
        @(negedge clk);
        a_clear = 0; a_wr = 0; a_din = 0; a_psel = 0; a_pwrite = 0; a_oclr = 0;
        b_clear = 0; b_wr = 0; b_din = 0; b_psel = 0; b_pwrite = 0; b_oclr = 0;
        if (sel == 0) begin
            a_clear = clr; a_wr = wr; a_din = din; a_psel = psel; a_pwrite = pwrite; a_oclr = oclr;
        end else begin
            b_clear = clr; b_wr = wr; b_din = din; b_psel = psel; b_pwrite = pwrite; b_oclr = oclr;
        end
        @(posedge clk);
        model_step(sel, clr, wr, din, psel, pwrite, oclr);
        #1;
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        cycle(sel, 0, 1, d, 0, 0, 0);
    endtask

    task automatic pop(input int sel);
        cycle(sel, 0, 0, 8'h00, 1, 0, 0);
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            act_out = a_out; act_empty = a_empty; act_full = a_full;
            act_cnt = int'(a_cnt); act_intr = a_intr; act_ovr = a_ovr;
        end else begin
            act_out = b_out; act_empty = b_empty; act_full = b_full;
            act_cnt = int'(b_cnt); act_intr = b_intr; act_ovr = b_ovr;
        end
    endtask

    task automatic model_expect(input int sel);
        int dep, wm, sz;
        dep = (sel == 0) ? 4 : 8;
        wm  = (sel == 0) ? 4 : 3;
        sz  = (sel == 0) ? qa.size() : qb.size();
        if (sz == 0)       exp_out = 8'h00;
        else if (sel == 0) exp_out = qa[0];
        else               exp_out = qb[0];
        exp_cnt   = sz;
        exp_empty = (sz == 0);
        exp_full  = (sz == dep);
        exp_intr  = (sz >= wm);
        exp_ovr   = m_ovr[sel];
    endtask

    task automatic test_reset;
        cycle(1, 1, 0, 8'h00, 0, 0, 0);
        cycle(0, 1, 0, 8'h00, 0, 0, 0);
        sample(0);
        n_tests++; if (act_out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", act_out); end
        n_tests++; if (act_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", act_empty); end
        n_tests++; if (act_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", act_full); end
        n_tests++; if (act_cnt !== 0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", act_cnt); end
        n_tests++; if (act_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr got=%0b exp=0", act_intr); end
        n_tests++; if (act_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%0b exp=0", act_ovr); end
    endtask

    task automatic test_fill_drain;
        logic [7:0] seq[4];
        seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) push(0, seq[i]);
        sample(0);
        n_tests++; if (act_cnt !== 4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", act_cnt); end
        n_tests++; if (act_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%0b exp=1", act_full); end
        n_tests++; if (act_intr !== 1'b1) begin n_fail++; $display("FAIL fill_intr got=%0b exp=1", act_intr); end
        for (int i = 0; i < 4; i++) begin
            sample(0);
            n_tests++;
            if (act_out !== seq[i]) begin n_fail++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, act_out, seq[i]); end
            pop(0);
        end
        sample(0);
        n_tests++; if (act_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%0b exp=1", act_empty); end
        n_tests++; if (act_out !== 8'h00) begin n_fail++; $display("FAIL drain_out got=%h exp=00", act_out); end
    endtask

    task automatic test_push_pop_full;
        logic [7:0] seq[4];
        seq = '{8'h20, 8'h30, 8'h40, 8'h55};
        push(0, 8'h10); push(0, 8'h20); push(0, 8'h30); push(0, 8'h40);
        cycle(0, 0, 1, 8'h55, 1, 0, 0);
        sample(0);
        n_tests++; if (act_cnt !== 4) begin n_fail++; $display("FAIL pp_full_count got=%0d exp=4", act_cnt); end
        for (int i = 0; i < 4; i++) begin
            sample(0);
            n_tests++;
            if (act_out !== seq[i]) begin n_fail++; $display("FAIL pp_full_data[%0d] got=%h exp=%h", i, act_out, seq[i]); end
            pop(0);
        end
    endtask

    task automatic test_empty_edges;
        pop(0);
        sample(0);
        n_tests++; if (act_cnt !== 0) begin n_fail++; $display("FAIL pop_empty_count got=%0d exp=0", act_cnt); end
        n_tests++; if (act_empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty_flag got=%0b exp=1", act_empty); end
        cycle(0, 0, 1, 8'h11, 1, 0, 0);
        sample(0);
        n_tests++; if (act_cnt !== 1) begin n_fail++; $display("FAIL push_pop_empty_count got=%0d exp=1", act_cnt); end
        n_tests++; if (act_out !== 8'h11) begin n_fail++; $display("FAIL push_pop_empty_out got=%h exp=11", act_out); end
        pop(0);
    endtask

    task automatic test_overrun;
        logic [7:0] seq[4];
        seq = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        for (int i = 0; i < 4; i++) push(0, seq[i]);
        push(0, 8'h99);
        sample(0);
        n_tests++; if (act_ovr !== c_OVR_EN) begin n_fail++; $display("FAIL ovr_set got=%0b exp=%0b", act_ovr, c_OVR_EN); end
        n_tests++; if (act_cnt !== 4) begin n_fail++; $display("FAIL ovr_count got=%0d exp=4", act_cnt); end
        n_tests++; if (act_out !== 8'hE1) begin n_fail++; $display("FAIL ovr_head got=%h exp=e1", act_out); end
        cycle(0, 0, 0, 8'h00, 0, 0, 1);
        sample(0);
        n_tests++; if (act_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got=%0b exp=0", act_ovr); end
        // Drop and clear on the same edge: the drop wins.
        cycle(0, 0, 1, 8'h9A, 0, 0, 1);
        sample(0);
        n_tests++; if (act_ovr !== c_OVR_EN) begin n_fail++; $display("FAIL ovr_set_wins got=%0b exp=%0b", act_ovr, c_OVR_EN); end
        cycle(0, 0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            sample(0);
            n_tests++;
            if (act_out !== seq[i]) begin n_fail++; $display("FAIL ovr_data[%0d] got=%h exp=%h", i, act_out, seq[i]); end
            pop(0);
        end
        sample(0);
        n_tests++; if (act_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_dropped got_empty=%0b exp=1", act_empty); end
    endtask

    task automatic test_wrap_watermark;
        cycle(1, 1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) push(1, 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 1, 8'(8'h60 + i), 1, 0, 0);
            sample(1); model_expect(1);
            n_tests++;
            if (act_out !== exp_out || act_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL wrap[%0d] got=%h/%0d exp=%h/%0d", i, act_out, act_cnt, exp_out, exp_cnt);
            end
        end
        cycle(1, 1, 0, 8'h00, 0, 0, 0);
        push(1, 8'h01); push(1, 8'h02);
        sample(1);
        n_tests++; if (act_intr !== 1'b0) begin n_fail++; $display("FAIL wm_at2 got=%0b exp=0", act_intr); end
        push(1, 8'h03);
        sample(1);
        n_tests++; if (act_intr !== 1'b1) begin n_fail++; $display("FAIL wm_rise got=%0b exp=1", act_intr); end
        pop(1);
        sample(1);
        n_tests++; if (act_intr !== 1'b0) begin n_fail++; $display("FAIL wm_fall got=%0b exp=0", act_intr); end
    endtask

    task automatic test_mid_reset;
        cycle(0, 1, 0, 8'h00, 0, 0, 0);
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        cycle(0, 1, 1, 8'h44, 1, 0, 0);
        sample(0);
        n_tests++; if (act_cnt !== 0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", act_cnt); end
        n_tests++; if (act_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got=%0b exp=1", act_empty); end
        n_tests++; if (act_intr !== 1'b0) begin n_fail++; $display("FAIL midrst_intr got=%0b exp=0", act_intr); end
        n_tests++; if (act_ovr !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr got=%0b exp=0", act_ovr); end
        n_tests++; if (act_out !== 8'h00) begin n_fail++; $display("FAIL midrst_out got=%h exp=00", act_out); end
        push(0, 8'h77);
        sample(0);
        n_tests++; if (act_out !== 8'h77) begin n_fail++; $display("FAIL midrst_after got=%h exp=77", act_out); end
    endtask

    task automatic test_random(input int sel);
        bit clr, wr, psel, pwrite, oclr;
        for (int i = 0; i < 300; i++) begin
            clr    = ($urandom_range(0, 63) == 0);
            wr     = ($urandom_range(0, 99) < 55);
            psel   = ($urandom_range(0, 99) < 60);
            pwrite = ($urandom_range(0, 99) < 25);
            oclr   = ($urandom_range(0, 9) == 0);
            cycle(sel, clr, wr, 8'($urandom), psel, pwrite, oclr);
            sample(sel); model_expect(sel);
            n_tests++; if (act_out !== exp_out) begin n_fail++; $display("FAIL rand%0d_out[%0d] got=%h exp=%h", sel, i, act_out, exp_out); end
            n_tests++; if (act_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand%0d_count[%0d] got=%0d exp=%0d", sel, i, act_cnt, exp_cnt); end
            n_tests++; if (act_empty !== exp_empty || act_full !== exp_full) begin
                n_fail++; $display("FAIL rand%0d_flags[%0d] got=%0b%0b exp=%0b%0b", sel, i, act_empty, act_full, exp_empty, exp_full);
            end
            n_tests++; if (act_intr !== exp_intr) begin n_fail++; $display("FAIL rand%0d_intr[%0d] got=%0b exp=%0b", sel, i, act_intr, exp_intr); end
            n_tests++; if (act_ovr !== exp_ovr) begin n_fail++; $display("FAIL rand%0d_ovr[%0d] got=%0b exp=%0b", sel, i, act_ovr, exp_ovr); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_push_pop_full();
        test_empty_edges();
        test_overrun();
        test_wrap_watermark();
        test_mid_reset();
        test_random(0);
        test_random(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
